// File: rtl/rpl_cap_pkg.sv
// Shared widths, event encodings and record layouts for the RPL capture stage.
package rpl_cap_pkg;

  localparam int unsigned CAP_POS_W = 16;
  localparam int unsigned CAP_SYM_W = 8;
  localparam int unsigned CAP_SLOTS = 64;
  localparam int unsigned IDX_W     = $clog2(CAP_SLOTS);
  // Slot count must reach CAP_SLOTS itself, hence one extra bit.
  localparam int unsigned CNT_W     = IDX_W + 1;

  typedef enum logic [2:0] {
    OP_OPEN    = 3'd0,
    OP_CLOSE   = 3'd1,
    OP_PUSH    = 3'd2,
    OP_COMMIT  = 3'd3,
    OP_RESTORE = 3'd4,
    OP_FINISH  = 3'd5
  } ev_op_e;

  typedef struct packed {
    logic [CAP_SYM_W-1:0] sym;
    logic [CAP_POS_W-1:0] start_pos;
    logic [CAP_POS_W-1:0] end_pos;
    logic [IDX_W-1:0]     level;
    logic [IDX_W-1:0]     parent;
    logic                 matched;
  } cap_rec_t;

  typedef struct packed {
    logic [IDX_W-1:0] capidx;
    logic [CNT_W-1:0] cnt;
  } bt_entry_t;

endpackage

// File: rtl/rpl_cap_btstack.sv
// Checkpoint LIFO: holds {capidx, cnt} snapshots for commit/restore.
module rpl_cap_btstack
  import rpl_cap_pkg::*;
#(
  parameter int unsigned BT_DEPTH = 16
) (
  input  logic      clk,
  input  logic      rst_n,
  input  logic      clr_i,
  input  logic      push_i,
  input  logic      pop_i,
  input  bt_entry_t push_data_i,
  output bt_entry_t top_c_o,
  output logic      full_o,
  output logic      empty_o
);

  localparam int unsigned SP_W  = $clog2(BT_DEPTH + 1);
  localparam int unsigned PTR_W = $clog2(BT_DEPTH);

  logic [SP_W-1:0] sp_q, sp_d;
  bt_entry_t       mem_q [BT_DEPTH];
  logic            wr_en;

  assign wr_en   = push_i && !clr_i && (sp_q != SP_W'(BT_DEPTH));
  assign top_c_o = mem_q[PTR_W'(sp_q - SP_W'(1))];

  always_comb begin
    sp_d = sp_q;
    if (clr_i) begin
      sp_d = '0;
    end else if (wr_en) begin
      sp_d = sp_q + SP_W'(1);
    end else if (pop_i && (sp_q != '0)) begin
      sp_d = sp_q - SP_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sp_q    <= '0;
      full_o  <= 1'b0;
      empty_o <= 1'b1;
      for (int i = 0; i < BT_DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      sp_q    <= sp_d;
      full_o  <= (sp_d == SP_W'(BT_DEPTH));
      empty_o <= (sp_d == '0);
      if (wr_en) begin
        mem_q[PTR_W'(sp_q)] <= push_data_i;
      end
    end
  end

endmodule

// File: rtl/rpl_capture_unit.sv
// Capture tree bookkeeping with checkpoint rollback; streams matched records
// in index order once the core signals end of match.
module rpl_capture_unit
  import rpl_cap_pkg::*;
#(
  parameter int unsigned POS_W     = CAP_POS_W,
  parameter int unsigned SYM_W     = CAP_SYM_W,
  parameter int unsigned CAP_DEPTH = CAP_SLOTS,
  parameter int unsigned BT_DEPTH  = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             ev_valid,
  output logic             ev_ready,
  input  logic [2:0]       ev_op,
  input  logic [SYM_W-1:0] ev_sym,
  input  logic [POS_W-1:0] ev_pos,
  output logic [IDX_W-1:0] cur_idx,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [SYM_W-1:0] out_sym,
  output logic [POS_W-1:0] out_start,
  output logic [POS_W-1:0] out_end,
  output logic [IDX_W-1:0] out_level,
  output logic             done,
  output logic             matched,
  output logic             err
);

  typedef enum logic [1:0] {
    ST_ACCEPT = 2'd0,
    ST_DRAIN  = 2'd1,
    ST_DONE   = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] rd_q, rd_d;
  logic [IDX_W-1:0] capidx_q, capidx_d;
  logic             err_q, err_d;
  logic             matched_q, matched_d;
  logic             done_q;
  logic             ev_ready_q;

  cap_rec_t         rec_q [CAP_DEPTH];
  cap_rec_t         cur_rec, drain_rec, rec_wdata;
  logic             rec_we;
  logic [IDX_W-1:0] rec_waddr;

  logic             bt_push, bt_pop, bt_clr, bt_full, bt_empty;
  bt_entry_t        bt_wdata, bt_top;

  rpl_cap_btstack #(
    .BT_DEPTH (BT_DEPTH)
  ) u_btstack (
    .clk         (clk),
    .rst_n       (rst_n),
    .clr_i       (bt_clr),
    .push_i      (bt_push),
    .pop_i       (bt_pop),
    .push_data_i (bt_wdata),
    .top_c_o     (bt_top),
    .full_o      (bt_full),
    .empty_o     (bt_empty)
  );

  assign cur_rec   = rec_q[capidx_q];
  assign drain_rec = rec_q[IDX_W'(rd_q)];

  assign ev_ready  = ev_ready_q;
  assign cur_idx   = capidx_q;
  assign done      = done_q;
  assign matched   = matched_q;
  assign err       = err_q;
  assign out_sym   = SYM_W'(drain_rec.sym);
  assign out_start = POS_W'(drain_rec.start_pos);
  assign out_end   = POS_W'(drain_rec.end_pos);
  assign out_level = drain_rec.level;

  // Event decode, drain walk and end-of-match cleanup.
  always_comb begin
    state_d         = state_q;
    cnt_d           = cnt_q;
    rd_d            = rd_q;
    capidx_d        = capidx_q;
    err_d           = err_q;
    matched_d       = matched_q;
    rec_we          = 1'b0;
    rec_waddr       = '0;
    rec_wdata       = '0;
    bt_push         = 1'b0;
    bt_pop          = 1'b0;
    bt_clr          = 1'b0;
    bt_wdata.capidx = capidx_q;
    bt_wdata.cnt    = cnt_q;
    out_valid       = 1'b0;

    case (state_q)
      ST_ACCEPT: begin
        if (ev_valid) begin
          case (ev_op)
            OP_OPEN: begin
              if (cnt_q == CNT_W'(CAP_DEPTH)) begin
                err_d = 1'b1;
              end else begin
                rec_we              = 1'b1;
                rec_waddr           = IDX_W'(cnt_q);
                rec_wdata.sym       = CAP_SYM_W'(ev_sym);
                rec_wdata.start_pos = CAP_POS_W'(ev_pos);
                rec_wdata.end_pos   = '0;
                rec_wdata.level     = (cnt_q == '0) ? '0 : cur_rec.level + IDX_W'(1);
                rec_wdata.parent    = capidx_q;
                rec_wdata.matched   = 1'b0;
                capidx_d            = IDX_W'(cnt_q);
                cnt_d               = cnt_q + CNT_W'(1);
              end
            end
            OP_CLOSE: begin
              if (cnt_q == '0) begin
                err_d = 1'b1;
              end else begin
                rec_we            = 1'b1;
                rec_waddr         = capidx_q;
                rec_wdata         = cur_rec;
                rec_wdata.end_pos = CAP_POS_W'(ev_pos);
                rec_wdata.matched = 1'b1;
                capidx_d          = cur_rec.parent;
              end
            end
            OP_PUSH: begin
              if (bt_full) err_d = 1'b1;
              else         bt_push = 1'b1;
            end
            OP_COMMIT: begin
              if (bt_empty) begin
                err_d = 1'b1;
              end else begin
                bt_pop   = 1'b1;
                capidx_d = bt_top.capidx;
              end
            end
            OP_RESTORE: begin
              if (bt_empty) begin
                err_d = 1'b1;
              end else begin
                bt_pop   = 1'b1;
                capidx_d = bt_top.capidx;
                cnt_d    = bt_top.cnt;
              end
            end
            OP_FINISH: begin
              matched_d = (cnt_q != '0) && rec_q[0].matched;
              rd_d      = '0;
              bt_clr    = 1'b1;
              state_d   = ST_DRAIN;
            end
            default: err_d = 1'b1;
          endcase
        end
      end

      ST_DRAIN: begin
        if (rd_q != cnt_q) begin
          if (!drain_rec.matched) begin
            rd_d = rd_q + CNT_W'(1);
          end else begin
            out_valid = 1'b1;
            if (out_ready) rd_d = rd_q + CNT_W'(1);
          end
        end
        // Leaving on the last handshake/skip makes done land the next cycle.
        if (rd_d == cnt_q) state_d = ST_DONE;
      end

      ST_DONE: begin
        cnt_d    = '0;
        capidx_d = '0;
        rd_d     = '0;
        err_d    = 1'b0;
        bt_clr   = 1'b1;
        state_d  = ST_ACCEPT;
      end

      default: state_d = ST_ACCEPT;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_ACCEPT;
      cnt_q      <= '0;
      rd_q       <= '0;
      capidx_q   <= '0;
      err_q      <= 1'b0;
      matched_q  <= 1'b0;
      done_q     <= 1'b0;
      ev_ready_q <= 1'b1;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      rd_q       <= rd_d;
      capidx_q   <= capidx_d;
      err_q      <= err_d;
      matched_q  <= matched_d;
      done_q     <= (state_d == ST_DONE);
      ev_ready_q <= (state_d == ST_ACCEPT);
    end
  end

  // Record table: single write port, combinational reads.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < CAP_DEPTH; i++) begin
        rec_q[i] <= '0;
      end
    end else if (rec_we) begin
      rec_q[rec_waddr] <= rec_wdata;
    end
  end

endmodule
